// File: rtl/datapath_dump_pkg.sv
// datapath_dump_pkg: stream tags, halt causes and FSM states shared by the dump controller
package datapath_dump_pkg;

   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_REG = 2'd1;
   localparam logic [1:0] TAG_MEM = 2'd2;
   localparam logic [1:0] TAG_END = 2'd3;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_HALT    = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_RUN,
      S_DUMP_REG,
      S_DUMP_MEM,
      S_END,
      S_DONE
   } state_t;

endpackage

// File: rtl/dump_out_slice.sv
// dump_out_slice: registered valid/ready stage that holds data and tag steady under back-pressure
module dump_out_slice
   import datapath_dump_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_tag
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        tag_q, tag_d;

   assign in_ready = ~valid_q | out_ready;

   // Load a new word whenever the register is empty or being drained this cycle
   always_comb begin
      valid_d = in_ready ? in_valid : valid_q;
      data_d  = (in_valid & in_ready) ? in_data : data_q;
      tag_d   = (in_valid & in_ready) ? in_tag : tag_q;
   end

   // Output register; reset leaves the stream idle and zeroed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= TAG_PC;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_tag   = tag_q;

endmodule

// File: rtl/datapath_dump_ctrl.sv
// datapath_dump_ctrl: PC trace while running, then register/memory/END dump on halt or timeout
module datapath_dump_ctrl
   import datapath_dump_pkg::*;
#(
   parameter int                    DATA_W         = 32,
   parameter int                    NUM_REGS       = 32,
   parameter int                    RF_ADDR_W      = 5,
   parameter int                    MEM_ADDR_W     = 16,
   parameter logic [MEM_ADDR_W-1:0] MEM_BASE       = MEM_ADDR_W'('h4000),
   parameter int                    MEM_WORDS      = 4,
   parameter int                    TIMEOUT_CYCLES = 64,
   parameter logic [DATA_W-1:0]     HALT_INST      = '0,
   parameter bit                    TRACE_PC       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     pc,
   input  logic [DATA_W-1:0]     inst,
   output logic                  stall,
   output logic [RF_ADDR_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0]     rf_rdata,
   output logic [MEM_ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            out_tag,
   output logic                  done,
   output logic [1:0]            halt_cause
);

   localparam int IDX_MAX = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
   localparam int IW      = (IDX_MAX > 0) ? $clog2(IDX_MAX + 1) : 1;
   localparam int CW      = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [IW-1:0] LAST_REG = IW'((NUM_REGS > 0) ? NUM_REGS - 1 : 0);
   localparam logic [IW-1:0] LAST_MEM = IW'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

   // Empty phases are skipped by choosing the next populated state up front
   localparam state_t AFTER_RUN = (NUM_REGS > 0) ? S_DUMP_REG : (MEM_WORDS > 0) ? S_DUMP_MEM : S_END;
   localparam state_t AFTER_REG = (MEM_WORDS > 0) ? S_DUMP_MEM : S_END;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [1:0]        cause_q, cause_d;
   logic              done_q, done_d;
   logic              src_valid, src_ready;
   logic [DATA_W-1:0] src_data;
   logic [1:0]        src_tag;
   logic              halt_hit, timeout_hit;

   assign halt_hit    = (inst == HALT_INST);
   assign timeout_hit = (cnt_q == CNT_LAST);

   // Next-state, counters and the word offered to the output stage
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      cause_d   = cause_q;
      done_d    = done_q | (out_valid & out_ready & (out_tag == TAG_END));
      src_valid = 1'b0;
      src_data  = '0;
      src_tag   = TAG_PC;
      rf_raddr  = '0;
      mem_raddr = '0;
      stall     = 1'b1;
      case (state_q)
         S_RUN: begin
            stall     = out_valid & ~out_ready;
            src_valid = TRACE_PC;
            src_data  = pc;
            if (!stall) begin
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               cause_d = halt_hit ? CAUSE_HALT : timeout_hit ? CAUSE_TIMEOUT : cause_q;
               state_d = (halt_hit | timeout_hit) ? AFTER_RUN : S_RUN;
            end
         end
         S_DUMP_REG: begin
            rf_raddr  = RF_ADDR_W'(idx_q);
            src_valid = 1'b1;
            src_data  = rf_rdata;
            src_tag   = TAG_REG;
            if (src_ready) begin
               idx_d   = (idx_q == LAST_REG) ? '0 : idx_q + 1'b1;
               state_d = (idx_q == LAST_REG) ? AFTER_REG : S_DUMP_REG;
            end
         end
         S_DUMP_MEM: begin
            mem_raddr = MEM_BASE + MEM_ADDR_W'(idx_q);
            src_valid = 1'b1;
            src_data  = mem_rdata;
            src_tag   = TAG_MEM;
            if (src_ready) begin
               idx_d   = (idx_q == LAST_MEM) ? '0 : idx_q + 1'b1;
               state_d = (idx_q == LAST_MEM) ? S_END : S_DUMP_MEM;
            end
         end
         S_END: begin
            src_valid = 1'b1;
            src_data  = DATA_W'({cause_q, cnt_q});
            src_tag   = TAG_END;
            state_d   = src_ready ? S_DONE : S_END;
         end
         default: ;
      endcase
   end

   // Controller state; reset aborts any dump in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         idx_q   <= '0;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         done_q  <= done_d;
      end
   end

   dump_out_slice #(.DATA_W(DATA_W)) u_slice (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (src_valid),
      .in_ready  (src_ready),
      .in_data   (src_data),
      .in_tag    (src_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   assign done       = done_q;
   assign halt_cause = cause_q;

endmodule

// File: tb/tb_datapath_dump_ctrl.sv
// tb_datapath_dump_ctrl: directed checks of trace, dump ordering, back-pressure, wrap and reset abort
module tb_datapath_dump_ctrl;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, rst_w;
   logic [31:0] pc, inst, inst_w;
   logic        out_ready, out_ready_w;

   logic        stall, out_valid, done;
   logic [4:0]  rf_raddr;
   logic [15:0] mem_raddr;
   logic [31:0] rf_rdata, mem_rdata, out_data;
   logic [1:0]  out_tag, halt_cause;

   logic        stall_w, out_valid_w, done_w;
   logic [4:0]  rf_raddr_w;
   logic [15:0] mem_raddr_w;
   logic [31:0] rf_rdata_w, mem_rdata_w, out_data_w;
   logic [1:0]  out_tag_w, halt_cause_w;

   int          n_assert = 0;
   int          n_fail = 0;
   logic [33:0] q[$];
   logic [33:0] q2[$];
   logic        prev_stall = 1'b0;
   logic [33:0] prev_word = '0;
   logic [3:0]  pat = 4'b1001;
   int          nreg;

   always #5 clk = ~clk;

   function automatic logic [31:0] rv(input logic [4:0] a);
      return (a == 5'd3) ? 32'h0040_0200 : (32'hA500_0000 | {27'd0, a});
   endfunction

   assign rf_rdata    = rv(rf_raddr);
   assign mem_rdata   = {16'hBEEF, mem_raddr};
   assign rf_rdata_w  = rv(rf_raddr_w);
   assign mem_rdata_w = {16'hBEEF, mem_raddr_w};

   datapath_dump_ctrl u_dut (
      .clk(clk), .reset(reset), .pc(pc), .inst(inst), .stall(stall),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .done(done), .halt_cause(halt_cause)
   );

   datapath_dump_ctrl #(
      .NUM_REGS(0), .MEM_BASE(16'hFFFE), .MEM_WORDS(4), .TIMEOUT_CYCLES(4)
   ) u_wrap (
      .clk(clk), .reset(rst_w), .pc(pc), .inst(inst_w), .stall(stall_w),
      .rf_raddr(rf_raddr_w), .rf_rdata(rf_rdata_w), .mem_raddr(mem_raddr_w), .mem_rdata(mem_rdata_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w), .out_tag(out_tag_w),
      .done(done_w), .halt_cause(halt_cause_w)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Collect accepted words and check that a stalled word stays put
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) q.push_back({out_tag, out_data});
      if (!rst_w && out_valid_w && out_ready_w) q2.push_back({out_tag_w, out_data_w});
      if (!reset && prev_stall) chk("hold_stable", {out_valid, out_tag, out_data}, {1'b1, prev_word});
      prev_stall <= !reset && out_valid && !out_ready;
      prev_word  <= {out_tag, out_data};
   end

   task automatic do_reset;
      reset = 1'b1;
      out_ready = 1'b1;
      inst = NOP;
      tick;
      tick;
      reset = 1'b0;
      q.delete();
   endtask

   task automatic run_cycles(input int n, input logic [31:0] base, input int halt_at);
      for (int i = 0; i < n; i++) begin
         pc = base + 32'(4 * i);
         inst = (i == halt_at) ? HALT : NOP;
         tick;
      end
      inst = NOP;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int c = 0; c < budget && !done; c++) tick;
      chk({name, "_done"}, done, 1'b1);
      chk({name, "_idle_valid"}, out_valid, 1'b0);
      chk({name, "_idle_stall"}, stall, 1'b1);
   endtask

   task automatic check_dump(input string name, input int npc, input logic [31:0] pc0, input logic [31:0] end_w);
      int n;
      n = npc + 37;
      chk({name, "_len"}, q.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [33:0] e, o;
         if (i < npc) e = {2'd0, pc0 + 32'(4 * i)};
         else if (i < npc + 32) e = {2'd1, rv(5'(i - npc))};
         else if (i < npc + 36) e = {2'd2, 16'hBEEF, 16'h4000 + 16'(i - npc - 32)};
         else e = {2'd3, end_w};
         o = (i < q.size()) ? q[i] : 'x;
         chk($sformatf("%s_w%0d", name, i), o, e);
      end
   endtask

   initial begin
      reset = 1'b1;
      rst_w = 1'b1;
      pc = '0;
      inst = NOP;
      inst_w = NOP;
      out_ready = 1'b1;
      out_ready_w = 1'b1;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_tag", out_tag, 2'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cause", halt_cause, 2'd0);
      chk("rst_raddr", {rf_raddr, mem_raddr}, 21'h0);

      // Halt on the third cycle, free-flowing consumer
      do_reset;
      run_cycles(3, 32'h100, 2);
      chk("t1_cause", halt_cause, 2'd1);
      chk("t1_dump_stall", stall, 1'b1);
      wait_done("t1", 100);
      check_dump("t1", 3, 32'h100, 32'h83);
      tick;
      tick;
      chk("t1_hold_data", out_data, 32'h83);
      chk("t1_hold_done", done, 1'b1);

      // No halt: forced stop after 64 cycles
      do_reset;
      run_cycles(63, 32'h1000, -1);
      chk("t2_no_cause_yet", halt_cause, 2'd0);
      chk("t2_run_stall", stall, 1'b0);
      run_cycles(1, 32'h1000 + 32'd252, -1);
      chk("t2_cause", halt_cause, 2'd2);
      wait_done("t2", 100);
      check_dump("t2", 64, 32'h1000, 32'h140);

      // Back-pressure in RUN then 1-0-0-1 ready pattern through the dump
      do_reset;
      pc = 32'h200;
      out_ready = 1'b0;
      tick;
      chk("t3_run_stall", stall, 1'b1);
      chk("t3_run_data", out_data, 32'h200);
      pc = 32'h204;
      inst = HALT;
      tick;
      chk("t3_stalled_halt_ignored", halt_cause, 2'd0);
      chk("t3_still_stalled", stall, 1'b1);
      out_ready = 1'b1;
      tick;
      inst = NOP;
      chk("t3_cause", halt_cause, 2'd1);
      for (int k = 0; k < 400 && !done; k++) begin
         out_ready = pat[k % 4];
         tick;
      end
      out_ready = 1'b1;
      chk("t3_done", done, 1'b1);
      check_dump("t3", 2, 32'h200, 32'h82);

      // Halt and timeout in the same cycle: halt wins
      do_reset;
      run_cycles(64, 32'h2000, 63);
      chk("t5_cause", halt_cause, 2'd1);
      wait_done("t5", 100);
      check_dump("t5", 64, 32'h2000, 32'hC0);

      // Reset after ten registers, then a clean rerun from index 0
      do_reset;
      run_cycles(1, 32'h300, 0);
      nreg = 0;
      for (int c = 0; c < 60; c++) begin
         nreg = 0;
         foreach (q[i]) if (q[i][33:32] == 2'd1) nreg++;
         if (nreg >= 10) break;
         tick;
      end
      chk("t6_ten_regs", nreg, 10);
      reset = 1'b1;
      #1;
      chk("t6_abort_valid", out_valid, 1'b0);
      chk("t6_abort_data", out_data, 32'h0);
      chk("t6_abort_cause", halt_cause, 2'd0);
      chk("t6_abort_stall", stall, 1'b0);
      chk("t6_abort_raddr", rf_raddr, 5'd0);
      chk("t6_abort_done", done, 1'b0);
      tick;
      reset = 1'b0;
      q.delete();
      run_cycles(2, 32'h400, 1);
      wait_done("t6", 100);
      check_dump("t6", 2, 32'h400, 32'h82);

      // Second instance: no registers, memory window wraps past 0xFFFF, timeout of 4
      rst_w = 1'b0;
      run_cycles(4, 32'h500, -1);
      chk("t4_cause", halt_cause_w, 2'd2);
      chk("t4_skip_regs", rf_raddr_w, 5'd0);
      chk("t4_addr0", mem_raddr_w, 16'hFFFE);
      tick;
      chk("t4_addr1", mem_raddr_w, 16'hFFFF);
      tick;
      chk("t4_addr2", mem_raddr_w, 16'h0000);
      tick;
      chk("t4_addr3", mem_raddr_w, 16'h0001);
      for (int c = 0; c < 20 && !done_w; c++) tick;
      chk("t4_done", done_w, 1'b1);
      chk("t4_len", q2.size(), 9);
      for (int i = 0; i < 9; i++) begin
         logic [33:0] e, o;
         if (i < 4) e = {2'd0, 32'h500 + 32'(4 * i)};
         else if (i < 8) e = {2'd2, 16'hBEEF, 16'hFFFE + 16'(i - 4)};
         else e = {2'd3, 32'h14};
         o = (i < q2.size()) ? q2[i] : 'x;
         chk($sformatf("t4_w%0d", i), o, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
